fft_stage_ctrl: RTL and testbench



---
 rtl/fft_stage_ctrl.sv | 178 +++++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: sequencer for one shared radix-2 butterfly running an
// in-place decimation-in-time FFT on a dual-port sample RAM.
// Each stage issues N/2 read pairs with matching twiddle addresses.
// The write-back pairs are the same read pairs, delayed by RD_LAT+BF_LAT cycles.
// The pipeline drains between stages, so the next stage never reads a
// location whose write-back is still pending.
// Optional feature: define FFT_STAGE_CTRL_ABORT_EN to add an 'abort' input
// that cancels a running transform without a done pulse.
module fft_stage_ctrl #(
  parameter int LOG2N  = 4,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef FFT_STAGE_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int D = RD_LAT + BF_LAT;
  localparam logic [LOG2N-2:0] K_LAST = '1;
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic [LOG2N-2:0] k, k_nx;
  logic [LOG2N-1:0] stage_nx;
  logic             go_issue;
  logic             drain_last;
  logic             abort_hit;

  logic [LOG2N-1:0] kx, span, pos, grp, addr_a_nx, addr_b_nx, tw_shamt;
  logic [LOG2N-2:0] tw_nx;

  logic [D-1:0]     tag_v;
  logic [LOG2N-1:0] tag_a [D];
  logic [LOG2N-1:0] tag_b [D];

`ifdef FFT_STAGE_CTRL_ABORT_EN
  assign abort_hit = abort && ((state == ISSUE) || (state == DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  // The stage's last write-back is at the pipeline output and nothing is still behind it
  assign drain_last = tag_v[D-1] && (tag_v[D-2:0] == '0);
  assign go_issue   = (state_nx == ISSUE);

  // State register together with the butterfly counter and stage index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      stage <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      stage <= stage_nx;
    end
  end

  // Next-state logic: issue N/2 butterflies, drain, then advance stage or finish
  always_comb begin
    state_nx = state;
    k_nx     = k;
    stage_nx = stage;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ISSUE;
          k_nx     = '0;
          stage_nx = '0;
        end
      end
      ISSUE: begin
        if (k == K_LAST) state_nx = DRAIN;
        else             k_nx     = k + 1'b1;
      end
      DRAIN: begin
        if (drain_last) begin
          if (stage == S_LAST) begin
            state_nx = DONE;
          end else begin
            state_nx = ISSUE;
            stage_nx = stage + 1'b1;
            k_nx     = '0;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        stage_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
    if (abort_hit) begin
      state_nx = IDLE;
      stage_nx = '0;
      k_nx     = '0;
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy = (state == ISSUE) || (state == DRAIN);
    done = (state == DONE);
  end

  // Butterfly addressing for the upcoming read: insert a zero bit at position 'stage' into k
  always_comb begin
    kx        = {1'b0, k_nx};
    span      = {{(LOG2N-1){1'b0}}, 1'b1} << stage_nx;
    pos       = kx & (span - 1'b1);
    grp       = kx >> stage_nx;
    addr_a_nx = ((grp << stage_nx) << 1) | pos;
    addr_b_nx = addr_a_nx + span;
    tw_shamt  = S_LAST - stage_nx;
    tw_nx     = pos[LOG2N-2:0] << tw_shamt;
  end

  // Registered read-side outputs, which are zero whenever no read is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      rd_en     <= go_issue;
      rd_addr_a <= go_issue ? addr_a_nx : '0;
      rd_addr_b <= go_issue ? addr_b_nx : '0;
      tw_addr   <= go_issue ? tw_nx : '0;
    end
  end

  // Write-tag pipeline: delays each read pair by D cycles to form its write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i < D; i++) begin
        tag_a[i] <= '0;
        tag_b[i] <= '0;
      end
    end else if (abort_hit) begin
      tag_v <= '0;
      for (int i = 0; i < D; i++) begin
        tag_a[i] <= '0;
        tag_b[i] <= '0;
      end
    end else begin
      tag_v    <= {tag_v[D-2:0], rd_en};
      tag_a[0] <= rd_addr_a;
      tag_b[0] <= rd_addr_b;
      for (int i = 1; i < D; i++) begin
        tag_a[i] <= tag_a[i-1];
        tag_b[i] <= tag_b[i-1];
      end
    end
  end

  assign wr_en     = tag_v[D-1];
  assign wr_addr_a = tag_a[D-1];
  assign wr_addr_b = tag_b[D-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb_fft_stage_ctrl: randomized run-level bench for fft_stage_ctrl.
// The reference model tracks only the cycle offset since start.
// It derives every expected output from the stage schedule using plain arithmetic.
module tb_fft_stage_ctrl;
  localparam int LOG2N = 4;
  localparam int N     = 1 << LOG2N;
  localparam int HALF  = N / 2;
  localparam int D     = 5;
  localparam int SCYC  = HALF + D;
  localparam int TOTAL = LOG2N * SCYC + 1;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic             busy, done, rd_en, wr_en;
  logic [LOG2N-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2N-2:0] tw_addr;

  int numCompared = 0;
  int numMismatched = 0;
  int m = 0;
  int rdCount, wrCount;

  fft_stage_ctrl #(.LOG2N(LOG2N), .RD_LAT(1), .BF_LAT(4)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef FFT_STAGE_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t, offset %0d)", tag, observed, expected, $time, m);
    end
  endtask

  // Read issued c cycles after start was sampled: stage s, butterfly k
  function automatic void expRead(input int c, output bit en, output int a, output int b, output int tw);
    int s, w, span;
    en = 0; a = 0; b = 0; tw = 0;
    if (c >= 1 && c <= LOG2N * SCYC) begin
      s = (c - 1) / SCYC;
      w = (c - 1) % SCYC;
      if (w < HALF) begin
        span = 2 ** s;
        en   = 1;
        a    = (w / span) * 2 * span + (w % span);
        b    = a + span;
        tw   = (w % span) * (HALF / span);
      end
    end
  endfunction

  // Compare every output against the model for the current offset
  task automatic checkCycle();
    bit en, wen;
    int a, b, tw, wa, wb, unused;
    expRead(m, en, a, b, tw);
    expRead(m - D, wen, wa, wb, unused);
    checkOutput("rd_en", rd_en, en);
    if (en) begin
      checkOutput("rd_addr_a", rd_addr_a, a);
      checkOutput("rd_addr_b", rd_addr_b, b);
      checkOutput("tw_addr", tw_addr, tw);
    end
    checkOutput("wr_en", wr_en, wen);
    if (wen) begin
      checkOutput("wr_addr_a", wr_addr_a, wa);
      checkOutput("wr_addr_b", wr_addr_b, wb);
    end
    checkOutput("busy", busy, (m >= 1 && m < TOTAL) ? 1 : 0);
    checkOutput("done", done, (m == TOTAL) ? 1 : 0);
    if (m < TOTAL) checkOutput("stage", stage, (m == 0) ? 0 : (m - 1) / SCYC);
    if (rd_en === 1'b1) rdCount++;
    if (wr_en === 1'b1) wrCount++;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check
  task automatic applyStimulus(input logic st, input logic ab);
    start = st;
    abort = ab;
    @(posedge clk);
    if (m == 0) m = st ? 1 : 0;
    else if (m == TOTAL) m = 0;
`ifdef FFT_STAGE_CTRL_ABORT_EN
    else if (ab) m = 0;
`endif
    else m++;
    @(negedge clk);
    checkCycle();
  endtask

  // Asynchronous reset shortly after an edge, in the middle of a transform
  task automatic applyReset();
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    m++;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_stage", stage, 0);
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_rd_addr_a", rd_addr_a, 0);
    checkOutput("rst_tw_addr", tw_addr, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_addr_b", wr_addr_b, 0);
    m = 0;
    @(negedge clk);
    rst = 1'b0;
    checkCycle();
  endtask

  initial begin
    int gap, killAt, killKind, guard;
    bit killed;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    rdCount = 0;
    wrCount = 0;
    @(negedge clk);
    checkCycle();
    rst = 1'b0;
    gap = 1;
    for (int run = 0; run < 8; run++) begin
      repeat (gap) applyStimulus(1'b0, 1'b0);
      gap = $urandom_range(0, 3);
      killAt = 0;
      killKind = 0;
      if (run == 2) begin
        killAt = 29;
        killKind = 0;
      end else if (run > 2 && $urandom_range(0, 2) == 0) begin
        killAt = $urandom_range(2, 50);
`ifdef FFT_STAGE_CTRL_ABORT_EN
        killKind = $urandom_range(0, 1);
`endif
      end
      rdCount = 0;
      wrCount = 0;
      killed = 0;
      applyStimulus(1'b1, 1'b0);
      guard = 0;
      while (m != 0 && guard < 200) begin
        guard++;
        if (killAt != 0 && m == killAt) begin
          killed = 1;
          if (killKind == 0) begin
            applyReset();
          end else begin
            applyStimulus(1'b0, 1'b1);
            gap = 0;
          end
        end else begin
          applyStimulus((run == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
        end
      end
      checkOutput("run_terminated", (guard < 200) ? 1 : 0, 1);
      if (!killed) begin
        checkOutput("rd_en_cycles", rdCount, N / 2 * LOG2N);
        checkOutput("wr_en_cycles", wrCount, N / 2 * LOG2N);
      end
    end
    repeat (3) applyStimulus(1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
